// File: rtl/r22sdf_seq.sv
// Sequencer for an R22SDF FFT pipe: gates samples into the pipe, pads partial
// frames with zeros on flush, drains the pipe latency and tags pipe outputs
// with valid/last and their natural frequency index.

// Watches the outstanding-frame bookkeeping of r22sdf_seq.
module r22sdf_seq_chk #(
  parameter int OW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          inc,
  input logic          dec,
  input logic          idle_entry,
  input logic [OW-1:0] outst,
  input logic [OW-1:0] outst_nxt
);
  // Flag an underflow, and a drain that returns to idle with frames still in flight.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(dec && !inc && (outst == {OW{1'b0}})));
      assert (!idle_entry || (outst_nxt == {OW{1'b0}}));
    end
  end
endmodule

module r22sdf_seq #(
  parameter int STG = 2,
  parameter int LAT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             fft_en,
  output logic             fft_sync,
  output logic             fft_zero,
  output logic             out_valid,
  output logic [2*STG-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);
  localparam int IW  = 2 * STG;
  localparam int LEN = 1 << IW;
  localparam int LW  = $clog2(LAT + 1);
  localparam int OW  = $clog2(LAT / LEN + 3);

  localparam logic [IW-1:0] IZERO = {IW{1'b0}};
  localparam logic [IW-1:0] ILAST = {IW{1'b1}};
  localparam logic [LW-1:0] LZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LATV  = LW'(LAT);
  localparam logic [LW-1:0] FLAST = LW'(LAT - 1);
  localparam logic [OW-1:0] OZERO = {OW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAD   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e        state_r, state_nxt_s;
  logic [IW-1:0] icnt_r;
  logic [IW-1:0] ocnt_r;
  logic [LW-1:0] lcnt_r;
  logic [LW-1:0] fcnt_r;
  logic [OW-1:0] outst_r, outst_nxt_s;
  logic          flush_pend_r;

  logic rdy_s, en_s, zero_s;
  logic accept_s, inc_s, primed_s, ov_s, last_s, sync_s, idle_entry_s;

  // Output index is the bit-reversed output counter (pipe emits bit-reversed order).
  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    r = IZERO;
    for (int i = 0; i < IW; i++) begin
      r[i] = v[IW-1-i];
    end
    return r;
  endfunction

  // Next state plus the per-state handshake and pipe-enable controls; reset forces everything quiet.
  always_comb begin
    state_nxt_s = state_r;
    rdy_s       = 1'b0;
    en_s        = 1'b0;
    zero_s      = 1'b0;
    if (rst) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          rdy_s = ~flush_pend_r;
          en_s  = in_valid & rdy_s;
          if (en_s) begin
            state_nxt_s = S_RUN;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_RUN: begin
          rdy_s = ~flush_pend_r;
          en_s  = in_valid & rdy_s;
          // The cycle after a flush is latched decides between padding and draining.
          if (flush_pend_r) begin
            if (icnt_r == IZERO) begin
              state_nxt_s = S_FLUSH;
            end else begin
              state_nxt_s = S_PAD;
            end
          end else begin
            state_nxt_s = S_RUN;
          end
        end
        S_PAD: begin
          en_s   = 1'b1;
          zero_s = 1'b1;
          if (icnt_r == ILAST) begin
            state_nxt_s = S_FLUSH;
          end else begin
            state_nxt_s = S_PAD;
          end
        end
        S_FLUSH: begin
          en_s   = 1'b1;
          zero_s = 1'b1;
          if (fcnt_r == FLAST) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_FLUSH;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // Frame bookkeeping derived from the counters and this cycle's enable.
  always_comb begin
    accept_s     = in_valid & rdy_s;
    inc_s        = accept_s & (icnt_r == IZERO);
    primed_s     = (lcnt_r == LATV);
    ov_s         = en_s & primed_s & ((outst_r != OZERO) | inc_s);
    last_s       = ov_s & (ocnt_r == ILAST);
    sync_s       = en_s & (icnt_r == ILAST);
    idle_entry_s = (state_r == S_FLUSH) & (state_nxt_s == S_IDLE);
    case ({inc_s, last_s})
      2'b10:   outst_nxt_s = outst_r + 1'b1;
      2'b01:   outst_nxt_s = outst_r - 1'b1;
      default: outst_nxt_s = outst_r;
    endcase
  end

  // Drive the ports; index and busy are held at zero while reset is asserted.
  always_comb begin
    in_ready  = rdy_s;
    fft_en    = en_s;
    fft_zero  = zero_s;
    fft_sync  = sync_s;
    out_valid = ov_s;
    out_last  = last_s;
    if (rst) begin
      out_idx = IZERO;
      busy    = 1'b0;
    end else begin
      out_idx = bitrev(ocnt_r);
      busy    = (state_r != S_IDLE);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Input-frame position; restarted on return to idle so a new session begins a fresh frame.
  always_ff @(posedge clk) begin
    if (rst || idle_entry_s) begin
      icnt_r <= IZERO;
    end else if (en_s) begin
      icnt_r <= icnt_r + 1'b1;
    end else begin
      icnt_r <= icnt_r;
    end
  end

  // Pipe fill level (saturating at the latency) and cycles spent draining.
  always_ff @(posedge clk) begin
    if (rst || idle_entry_s) begin
      lcnt_r <= LZERO;
      fcnt_r <= LZERO;
    end else begin
      if (en_s && (lcnt_r != LATV)) begin
        lcnt_r <= lcnt_r + 1'b1;
      end else begin
        lcnt_r <= lcnt_r;
      end
      if (state_r == S_FLUSH) begin
        fcnt_r <= fcnt_r + 1'b1;
      end else begin
        fcnt_r <= LZERO;
      end
    end
  end

  // Output position within a frame and the count of real frames still in the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ocnt_r  <= IZERO;
      outst_r <= OZERO;
    end else begin
      if (ov_s) begin
        ocnt_r <= ocnt_r + 1'b1;
      end else begin
        ocnt_r <= ocnt_r;
      end
      outst_r <= outst_nxt_s;
    end
  end

  // Flush request latch; a flush alongside an accept still counts, idle flushes are dropped.
  always_ff @(posedge clk) begin
    if (rst || idle_entry_s) begin
      flush_pend_r <= 1'b0;
    end else if (flush && ((state_r == S_RUN) || accept_s)) begin
      flush_pend_r <= 1'b1;
    end else begin
      flush_pend_r <= flush_pend_r;
    end
  end

  r22sdf_seq_chk #(.OW(OW)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc_s),
    .dec        (last_s),
    .idle_entry (idle_entry_s),
    .outst      (outst_r),
    .outst_nxt  (outst_nxt_s)
  );
endmodule

// File: tb/tb_r22sdf_seq.sv
// Randomized and directed bench for r22sdf_seq against a frame-level model.
module tb_r22sdf_seq;
  localparam int STG = 2;
  localparam int IW  = 2 * STG;
  localparam int LEN = 16;
  localparam int LAT = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush;
  logic          in_ready, fft_en, fft_sync, fft_zero, out_valid, out_last, busy;
  logic [IW-1:0] out_idx;

  // Free-running clock.
  always #5 clk = ~clk;

  r22sdf_seq #(.STG(STG), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .fft_en    (fft_en),
    .fft_sync  (fft_sync),
    .fft_zero  (fft_zero),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  // Observed event counters, cleared per scenario.
  int cnt_en, cnt_zero, cnt_ov, cnt_last, cnt_sync;

  // Model: session-level view of the sequencer.
  bit m_busy, m_pend, m_decided;
  int m_zl;     // zero-data enables left to issue (pad + drain)
  int m_e;      // enables issued in this session
  int m_nout;   // valid outputs since reset
  bit fr[int];  // frames of this session started by a real sample

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < IW; i++) begin
      if (v[i]) r = r | (1 << (IW - 1 - i));
    end
    return r;
  endfunction

  task automatic clr_cnt();
    cnt_en = 0; cnt_zero = 0; cnt_ov = 0; cnt_last = 0; cnt_sync = 0;
  endtask

  task automatic step(input bit v, input bit f, input bit r);
    bit drain, rdy, acc, en, zero, sync, ov, last, was_busy, was_pend;
    int idx;
    in_valid = v;
    flush    = f;
    rst      = r;
    @(negedge clk);
    cnt_en   += int'(fft_en);
    cnt_zero += int'(fft_zero);
    cnt_ov   += int'(out_valid);
    cnt_last += int'(out_last);
    cnt_sync += int'(fft_sync);
    if (r) begin
      chk("rst_fft_en",    fft_en,    0);
      chk("rst_fft_sync",  fft_sync,  0);
      chk("rst_fft_zero",  fft_zero,  0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_busy",      busy,      0);
      chk("rst_out_idx",   out_idx,   0);
      m_busy = 0; m_pend = 0; m_decided = 0; m_zl = 0; m_e = 0; m_nout = 0;
      fr.delete();
    end else begin
      drain = (m_zl > 0);
      rdy   = !m_pend && !drain;
      acc   = v && rdy;
      en    = drain || acc;
      zero  = drain;
      sync  = en && ((m_e % LEN) == LEN - 1);
      ov    = en && (m_e >= LAT) && fr.exists((m_e - LAT) / LEN);
      idx   = brev(m_nout % LEN);
      last  = ov && ((m_nout % LEN) == LEN - 1);
      chk("in_ready",  in_ready,  rdy);
      chk("fft_en",    fft_en,    en);
      chk("fft_zero",  fft_zero,  zero);
      chk("fft_sync",  fft_sync,  sync);
      chk("out_valid", out_valid, ov);
      chk("out_last",  out_last,  last);
      chk("out_idx",   out_idx,   idx);
      chk("busy",      busy,      m_busy);
      was_busy = m_busy;
      was_pend = m_pend;
      if (acc && ((m_e % LEN) == 0)) fr[m_e / LEN] = 1'b1;
      if (en) m_e++;
      if (ov) m_nout++;
      if (acc) m_busy = 1;
      if (was_pend && !m_decided && !drain) begin
        m_decided = 1;
        m_zl = ((LEN - (m_e % LEN)) % LEN) + LAT;
      end else if (drain) begin
        m_zl--;
        if (m_zl == 0) begin
          m_busy = 0; m_pend = 0; m_decided = 0; m_e = 0;
          fr.delete();
        end
      end
      if (f && !was_pend && (was_busy || acc)) m_pend = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    in_valid = 1'b1; flush = 1'b0; rst = 1'b1;
    m_busy = 0; m_pend = 0; m_decided = 0; m_zl = 0; m_e = 0; m_nout = 0;
    clr_cnt();
    @(posedge clk); #1;

    // Reset held two cycles with valid high.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // 48 back-to-back samples.
    clr_cnt();
    for (int i = 0; i < 48; i++) step(1'b1, 1'b0, 1'b0);
    chk("cont_sync_cnt", cnt_sync, 3);
    chk("cont_ov_cnt",   cnt_ov,   32);
    chk("cont_last_cnt", cnt_last, 2);
    step(1'b0, 1'b1, 1'b0);
    idle_n(40);
    chk("cont_busy_end", busy, 0);

    // Alternating valid: pipe stalls on gaps.
    clr_cnt();
    for (int i = 0; i < 64; i++) step(i % 2 == 0, 1'b0, 1'b0);
    chk("tog_en_cnt", cnt_en, 32);
    chk("tog_ov_cnt", cnt_ov, 16);
    step(1'b0, 1'b1, 1'b0);
    idle_n(40);

    // Five samples then flush: pad 11, drain 16.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    clr_cnt();
    step(1'b0, 1'b1, 1'b0);
    idle_n(40);
    chk("pad_zero_cnt", cnt_zero, 27);
    chk("pad_ov_cnt",   cnt_ov,   16);
    chk("pad_last_cnt", cnt_last, 1);
    chk("pad_sync_cnt", cnt_sync, 2);
    chk("pad_busy_end", busy,     0);

    // Flush while idle is ignored.
    clr_cnt();
    step(1'b0, 1'b1, 1'b0);
    idle_n(5);
    chk("idle_flush_en", cnt_en, 0);

    // Reset in the fifth drain cycle, then a fresh frame.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    clr_cnt();
    idle_n(4);
    chk("drain_zero_cnt", cnt_zero, 4);
    step(1'b0, 1'b0, 1'b1);
    clr_cnt();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    chk("post_rst_sync", cnt_sync, 1);
    chk("post_rst_ov",   cnt_ov,   0);
    step(1'b0, 1'b1, 1'b0);
    idle_n(40);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3, $urandom_range(0, 299) == 0);
    end
    step(1'b0, 1'b1, 1'b0);
    idle_n(50);
    chk("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
